// File: rtl/dpram_fifo_ctrl.sv
// Stream FIFO controller sequencing an external dual-port RAM (port A write, port B
// combinational read) with one registered output stage holding the head word.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  FLUSH,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  ALMOST_FULL,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AFULL = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] C_ZERO  = '0;

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_s_tready;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_overflow;

  logic [ADDR_WIDTH:0]   w_ram_cnt;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
  logic                  w_push;
  logic                  w_fetch;
  logic                  w_pop;

  // Handshakes: a push happens when S_TVALID && S_TREADY, a pop when M_TVALID && M_TREADY;
  // neither side may make valid depend on ready. FLUSH cancels both in its cycle.
  assign w_ram_cnt     = r_wr_ptr - r_rd_ptr;
  assign w_push        = S_TVALID && r_s_tready && !FLUSH;
  assign w_pop         = r_m_tvalid && M_TREADY;
  assign w_fetch       = (w_ram_cnt != C_ZERO) && (!r_m_tvalid || M_TREADY) && !FLUSH;
  assign w_ram_cnt_nxt = w_ram_cnt + {C_ZERO[ADDR_WIDTH:1], w_push}
                                   - {C_ZERO[ADDR_WIDTH:1], w_fetch};

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_s_tready <= 1'b1;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_overflow <= 1'b0;
    end else if (FLUSH) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_s_tready <= 1'b1;
      r_m_tvalid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_m_tdata  <= RAM_R_DATA;
        r_m_tvalid <= 1'b1;
      end else if (w_pop) begin
        r_m_tvalid <= 1'b0;
      end
      // Ready tracks next-cycle occupancy, so a fetch on a full RAM frees space one cycle later.
      r_s_tready <= (w_ram_cnt_nxt != C_DEPTH);
      if (S_TVALID && !r_s_tready) r_overflow <= 1'b1;
    end
  end

  assign S_TREADY    = r_s_tready;
  assign M_TVALID    = r_m_tvalid;
  assign M_TDATA     = r_m_tdata;
  assign OVERFLOW    = r_overflow;
  assign RAM_W_EN    = w_push && ARESETN;
  assign RAM_W_ADDR  = r_wr_ptr[ADDR_WIDTH-1:0];
  assign RAM_W_DATA  = S_TDATA;
  assign RAM_R_ADDR  = r_rd_ptr[ADDR_WIDTH-1:0];
  assign COUNT       = w_ram_cnt + {C_ZERO[ADDR_WIDTH:1], r_m_tvalid};
  assign ALMOST_FULL = (w_ram_cnt >= C_AFULL);

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: RAM model, queue-based reference model, scoreboard on
// popped words, directed scenarios followed by randomized traffic.
module tb_dpram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_w_en;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          overflow;

  // clock / reset
  always #5 aclk = ~aclk;

  dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFULL)) dut (
    .ACLK(aclk), .ARESETN(aresetn), .FLUSH(flush),
    .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TREADY(s_tready),
    .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TREADY(m_tready),
    .RAM_W_ADDR(ram_w_addr), .RAM_W_DATA(ram_w_data), .RAM_W_EN(ram_w_en),
    .RAM_R_ADDR(ram_r_addr), .RAM_R_DATA(ram_r_data),
    .COUNT(count), .ALMOST_FULL(almost_full), .OVERFLOW(overflow)
  );

  // dual-port RAM: synchronous write, combinational read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge aclk) if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
  assign ram_r_data = mem[ram_r_addr];

  // reference model: words held in RAM, the output stage, ready/overflow flags
  logic [DW-1:0] ram_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic          m_ready_q;
  logic          m_ovf_q;
  logic          model_known = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr,
                       input logic fl, input logic rst);
    logic          push, pop, fetch;
    logic [DW-1:0] w;
    s_tvalid = sv; s_tdata = sd; m_tready = mr; flush = fl; aresetn = rst;
    @(negedge aclk);
    if (model_known) begin
      check("s_tready", 32'(s_tready), 32'(m_ready_q));
      check("m_tvalid", 32'(m_tvalid), 32'(m_valid_q));
      if (m_valid_q) check("m_tdata", 32'(m_tdata), 32'(m_data_q));
      check("count", 32'(count), ram_q.size() + 32'(m_valid_q));
      check("almost_full", 32'(almost_full), 32'(ram_q.size() >= AFULL));
      check("overflow", 32'(overflow), 32'(m_ovf_q));
      check("ram_w_en", 32'(ram_w_en), 32'(rst && !fl && sv && m_ready_q));
      if (ram_w_en) check("ram_w_data", 32'(ram_w_data), 32'(sd));
      if (rst && !fl && m_valid_q && mr) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else begin
          w = exp_q.pop_front();
          check("pop_order", 32'(m_tdata), 32'(w));
        end
      end
    end
    if (!rst || fl) begin
      ram_q.delete(); exp_q.delete();
      m_valid_q = 1'b0; m_ready_q = 1'b1; m_ovf_q = 1'b0;
      if (!rst) begin
        m_data_q = '0;
        model_known = 1'b1;
      end
    end else begin
      push  = sv && m_ready_q;
      pop   = m_valid_q && mr;
      fetch = (ram_q.size() > 0) && (!m_valid_q || mr);
      if (sv && !m_ready_q) m_ovf_q = 1'b1;
      if (fetch) begin
        m_data_q  = ram_q.pop_front();
        m_valid_q = 1'b1;
      end else if (pop) m_valid_q = 1'b0;
      if (push) begin
        ram_q.push_back(sd);
        exp_q.push_back(sd);
      end
      m_ready_q = (ram_q.size() != DEPTH);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, mr, 1'b0, 1'b1);
  endtask

  initial begin
    // 1: reset, single word latency
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_m_tdata", 32'(m_tdata), 32'h0);
    check("rst_count", 32'(count), 32'd0);
    cycle(1'b1, 8'hca, 1'b0, 1'b0, 1'b1);
    check("lat_t1_valid", 32'(m_tvalid), 32'd0);
    idle(1, 1'b0);
    check("lat_t2_valid", 32'(m_tvalid), 32'd1);
    check("lat_t2_data", 32'(m_tdata), 32'hca);
    check("lat_t2_count", 32'(count), 32'd1);

    // 2: fill to DEPTH+1, then drain in order
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    check("fill_tready", 32'(s_tready), 32'd0);
    check("fill_count", 32'(count), 32'd17);
    idle(20, 1'b1);
    check("drain_count", 32'(count), 32'd0);

    // 3: streaming across pointer wrap
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // 4: full FIFO, push attempt coinciding with a pop
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    check("full_pop_tready_next", 32'(s_tready), 32'd1);
    check("full_overflow", 32'(overflow), 32'd1);
    idle(20, 1'b1);

    // 5: almost-full, then flush
    for (int i = 0; i < 13; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    check("afull", 32'(almost_full), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(m_tvalid), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_tready", 32'(s_tready), 32'd1);

    // 6: reset mid-stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(m_tvalid), 32'd0);
    check("mid_rst_tready", 32'(s_tready), 32'd1);
    cycle(1'b1, 8'hba, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    check("post_rst_data", 32'(m_tdata), 32'hba);
    check("post_rst_valid", 32'(m_tvalid), 32'd1);
    idle(2, 1'b1);

    // 7: randomized traffic with varying bias, occasional flush/reset
    for (int i = 0; i < 600; i++) begin
      logic sv, mr, fl, rst;
      if ((i / 100) % 2 == 0) begin
        sv = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 3) == 0);
      end else begin
        sv = ($urandom_range(0, 3) == 0);
        mr = ($urandom_range(0, 3) != 0);
      end
      fl  = ($urandom_range(0, 80) == 0);
      rst = ($urandom_range(0, 150) != 0);
      cycle(sv, 8'($urandom), mr, fl, rst);
    end
    idle(20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
